multicycle_main_fsm: RTL and testbench

MULTICYCLE_MAIN_FSM -- requirements
Module: multicycle_main_fsm

---
 rtl/multicycle_main_fsm.sv | 155 +++++++++++++++
 tb/tb_multicycle_main_fsm.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/multicycle_main_fsm.sv
// rtl/multicycle_main_fsm.sv - multicycle processor main control FSM
// Moore decode of State; write enables are gated off combinationally while reset is high.
module multicycle_main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       Branch,
  output logic       PCWrite,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] ADDIEX = 4'd9;
  localparam logic [3:0] ADDIWB = 4'd10;
  localparam logic [3:0] JUMP   = 4'd11;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       started_q;

  // started_q holds the FSM in FETCH for the first edge after reset release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = FETCH;
    if (started_q) begin
      case (state_q)
        FETCH:  state_d = DECODE;
        DECODE: begin
          case (Op)
            OP_LW, OP_SW: state_d = MEMADR;
            OP_RTYP:      state_d = EXEC;
            OP_BEQ:       state_d = BRANCH;
            OP_ADDI:      state_d = ADDIEX;
            OP_J:         state_d = JUMP;
            default:      state_d = FETCH;
          endcase
        end
        MEMADR: state_d = (Op == OP_LW) ? MEMRD : MEMWR;
        MEMRD:  state_d = MEMWB;
        EXEC:   state_d = ALUWB;
        ADDIEX: state_d = ADDIWB;
        default: state_d = FETCH;
      endcase
    end
  end

  always_comb begin
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    Branch   = 1'b0;
    PCWrite  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 2'b00;
    Illegal  = 1'b0;
    case (state_q)
      FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        Illegal = !(Op == OP_LW || Op == OP_SW || Op == OP_RTYP ||
                    Op == OP_BEQ || Op == OP_ADDI || Op == OP_J);
      end
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: IorD = 1'b1;
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
      end
      ADDIWB: RegWrite = 1'b1;
      JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    // reset forces state_q to FETCH already; only the write enables need masking
    if (reset) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign PCEn  = PCWrite | (Branch & Zero);
  assign State = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb/tb_multicycle_main_fsm.sv - directed self-checking bench for multicycle_main_fsm
module tb_multicycle_main_fsm;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic       Zero;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic       ALUSrcA, Branch, PCWrite, PCEn, Illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  multicycle_main_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .Branch(Branch), .PCWrite(PCWrite), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .PCEn(PCEn), .Illegal(Illegal), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    Op    = 6'b000000;
    Zero  = 1'b0;
    #3;
    chk("rst_state", 8'(State), 8'd0);
    chk("rst_irwrite", 8'(IRWrite), 8'd0);
    chk("rst_pcwrite", 8'(PCWrite), 8'd0);
    chk("rst_pcen", 8'(PCEn), 8'd0);
    chk("rst_alusrcb", 8'(ALUSrcB), 8'd1);
    chk("rst_illegal", 8'(Illegal), 8'd0);
    @(negedge clk);
    reset = 1'b0;
    Op    = 6'b100011;
    #1;
    chk("fetch_irwrite", 8'(IRWrite), 8'd1);
    chk("fetch_pcen", 8'(PCEn), 8'd1);

    // lw: first edge holds FETCH, then 1,2,3,4,0
    step(); chk("post_rst_hold", 8'(State), 8'd0);
    step(); chk("lw_s1", 8'(State), 8'd1);
    chk("dec_alusrcb", 8'(ALUSrcB), 8'd3);
    chk("dec_illegal", 8'(Illegal), 8'd0);
    step(); chk("lw_s2", 8'(State), 8'd2);
    chk("memadr_alusrcb", 8'(ALUSrcB), 8'd2);
    step(); chk("lw_s3", 8'(State), 8'd3);
    chk("memrd_iord", 8'(IorD), 8'd1);
    chk("memrd_regwrite", 8'(RegWrite), 8'd0);
    step(); chk("lw_s4", 8'(State), 8'd4);
    chk("memwb_regwrite", 8'(RegWrite), 8'd1);
    chk("memwb_memtoreg", 8'(MemtoReg), 8'd1);
    step(); chk("lw_s0", 8'(State), 8'd0);
    chk("lw_memtoreg0", 8'(MemtoReg), 8'd0);

    // R-type
    Op = 6'b000000;
    step(); chk("r_s1", 8'(State), 8'd1);
    step(); chk("r_s6", 8'(State), 8'd6);
    chk("exec_aluop", 8'(ALUOp), 8'd2);
    chk("exec_alusrca", 8'(ALUSrcA), 8'd1);
    step(); chk("r_s7", 8'(State), 8'd7);
    chk("aluwb_regdst", 8'(RegDst), 8'd1);
    chk("aluwb_regwrite", 8'(RegWrite), 8'd1);
    step(); chk("r_s0", 8'(State), 8'd0);

    // beq taken, with Op changed mid-branch (must be ignored)
    Op = 6'b000100; Zero = 1'b1;
    step(); chk("beq_s1", 8'(State), 8'd1);
    chk("fetch_pcen_no_branch", 8'(PCEn), 8'd0);
    step(); chk("beq_s8", 8'(State), 8'd8);
    chk("beq_pcen_z1", 8'(PCEn), 8'd1);
    chk("beq_pcsrc", 8'(PCSrc), 8'd1);
    chk("beq_aluop", 8'(ALUOp), 8'd1);
    Zero = 1'b0; #1;
    chk("beq_pcen_z0_same", 8'(PCEn), 8'd0);
    Op = 6'b100011;
    step(); chk("beq_s0", 8'(State), 8'd0);

    // beq not taken
    Op = 6'b000100; Zero = 1'b0;
    step(); chk("beq2_s1", 8'(State), 8'd1);
    step(); chk("beq2_s8", 8'(State), 8'd8);
    chk("beq2_pcen", 8'(PCEn), 8'd0);
    step(); chk("beq2_s0", 8'(State), 8'd0);

    // addi
    Op = 6'b001000;
    step(); chk("addi_s1", 8'(State), 8'd1);
    step(); chk("addi_s9", 8'(State), 8'd9);
    chk("addiex_alusrcb", 8'(ALUSrcB), 8'd2);
    step(); chk("addi_s10", 8'(State), 8'd10);
    chk("addiwb_regwrite", 8'(RegWrite), 8'd1);
    chk("addiwb_regdst", 8'(RegDst), 8'd0);
    step(); chk("addi_s0", 8'(State), 8'd0);

    // jump
    Op = 6'b000010;
    step(); chk("j_s1", 8'(State), 8'd1);
    step(); chk("j_s11", 8'(State), 8'd11);
    chk("j_pcsrc", 8'(PCSrc), 8'd2);
    chk("j_pcen", 8'(PCEn), 8'd1);
    step(); chk("j_s0", 8'(State), 8'd0);

    // illegal opcode
    Op = 6'b111111;
    step(); chk("ill_s1", 8'(State), 8'd1);
    chk("ill_flag", 8'(Illegal), 8'd1);
    step(); chk("ill_s0", 8'(State), 8'd0);
    chk("ill_flag_clr", 8'(Illegal), 8'd0);

    // sw with asynchronous reset in MEMWR
    Op = 6'b101011;
    step(); chk("sw_s1", 8'(State), 8'd1);
    step(); chk("sw_s2", 8'(State), 8'd2);
    step(); chk("sw_s5", 8'(State), 8'd5);
    chk("memwr_memwrite", 8'(MemWrite), 8'd1);
    chk("memwr_iord", 8'(IorD), 8'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_state", 8'(State), 8'd0);
    chk("async_rst_memwrite", 8'(MemWrite), 8'd0);
    chk("async_rst_irwrite", 8'(IRWrite), 8'd0);
    @(negedge clk);
    reset = 1'b0;
    step(); chk("rst2_hold", 8'(State), 8'd0);
    step(); chk("rst2_s1", 8'(State), 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
